frame_align: RTL
================

# frame_align

Receive-side frame aligner between the serial receiver and the demapper. It takes the raw byte stream from the serial receiver and hunts for the two-byte frame alignment signal (FAS). It declares in-frame after repeated FAS matches at the frame period, then forwards aligned bytes to the demapper with a FAS strobe on the first byte of every frame. Loss of frame is declared after consecutive FAS misses, and the block then returns to hunting.

## Interface
- FRAME_BYTES, 8704, bytes per frame including FAS (4 rows x 2176 cols); must be >= 4
- FAS_B0, 8'hF6, first FAS byte (frame position 0)
- FAS_B1, 8'h28, second FAS byte (frame position 1)
- ENTER_CNT, 2, consecutive period-aligned FAS matches after the initial hunt match required to enter SYNC
- EXIT_CNT, 4, consecutive FAS misses in SYNC that declare loss of frame
- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_rx_data  in  8  byte from serial receiver
- i_rx_data_valid  in  1  byte strobe; no backpressure, gaps allowed
- o_frame_data  out  8  aligned byte to demapper
- o_frame_data_valid  out  1  aligned byte strobe, asserted only in SYNC
- o_frame_data_fas  out  1  asserted with o_frame_data_valid on frame position 0
- o_lof  out  1  loss of frame, 1 in every state except SYNC
- o_fas_err_cnt  out  16  saturating count of FAS misses seen in SYNC

## Operation
- hold register: keeps the previous valid byte; the compare window is {hold, i_rx_data} on each valid beat.
- pos counter: counts valid bytes modulo FRAME_BYTES; position 0 is FAS_B0.
  - Wraps FRAME_BYTES-1 -> 0.
  - The FAS check occurs on the beat where pos == 1.
- States: HUNT, PRESYNC, SYNC. Reset state is HUNT.
- HUNT: window compared on every valid beat.
  - On match, pos := 2, match_cnt := 0, go to PRESYNC.
- PRESYNC: at pos == 1:
  - Match: match_cnt += 1; when match_cnt reaches ENTER_CNT, go to SYNC with miss_cnt := 0.
  - Miss: go to HUNT. The same beat is not re-tested as a hunt candidate.
- SYNC: at pos == 1:
  - Match: miss_cnt := 0.
  - Miss: miss_cnt += 1 and o_fas_err_cnt += 1 (saturates at 16'hFFFF); when miss_cnt reaches EXIT_CNT, go to HUNT.
  - While fewer than EXIT_CNT misses have occurred, alignment flywheels on pos; no realignment is done.
- Output: on each valid beat, the hold byte is emitted if the state after evaluating that beat is SYNC.
  - o_frame_data_fas = (hold byte position == 0).
  - The first emitted byte after entering SYNC is therefore FAS_B0 of the confirming frame, with fas = 1.
- On exit to HUNT, output stops on that same beat; the demapper sees a truncated frame and realigns on the next fas.
- Width rules: pos is clog2(FRAME_BYTES) bits; match_cnt and miss_cnt are 3 bits.

## Timing
- Reset (async assert, synchronous-release use) values:
  - state = HUNT, pos = 0, hold = 0, counters = 0
  - o_frame_data = 0, o_frame_data_valid = 0, o_frame_data_fas = 0, o_lof = 1, o_fas_err_cnt = 0
- All outputs are registered.
  - The byte accepted on valid beat n appears on the outputs the cycle after valid beat n+1.
  - Latency is 1 valid beat + 1 clock.
- o_frame_data_valid and o_frame_data_fas are single-cycle pulses per accepted input beat.
  - Never asserted without i_rx_data_valid in the previous cycle.
- o_lof updates the cycle after the state change: falls on entering SYNC, rises on leaving it.
- Idle cycles (i_rx_data_valid = 0) freeze all state, counters and hold.
- Reset mid-frame returns the block to HUNT immediately; any partial output is abandoned.
- FAS pattern embedded in the payload:
  - In HUNT it may cause a false PRESYNC, which is rejected by the period check.
  - In SYNC it is ignored.

## Structure
- Shared include frame_defs.vh (also used by mapper, demapper and fpc):
  - FRAME_ROWS, FRAME_COLS, FRAME_BYTES
  - FAS_B0, FAS_B1
  - state encodings for HUNT, PRESYNC, SYNC
- One sub-module, fas_sync_fsm: state, match_cnt, miss_cnt and the error counter, driven by a per-beat match flag and a check strobe.
- The top level holds the hold register, the pos counter and the output registers.

## Test plan
- **Clean acquisition:** reset, then 5 back-to-back frames with F6 28 at position 0.
  - Required: SYNC and o_lof = 0 after the 3rd FAS.
  - First output byte F6 with fas = 1; exactly FRAME_BYTES bytes between consecutive fas pulses.
- **False FAS in payload:** F6 28 at position 100 of the first frame, true FAS at position 0 from the second frame.
  - Required: PRESYNC, then HUNT on the period miss, then SYNC locked on the true positions.
- **Flywheel:** in SYNC, corrupt 3 consecutive FAS.
  - Required: o_lof stays 0 and o_fas_err_cnt = 3; the next good FAS resets miss_cnt.
- **Loss of frame:** in SYNC, corrupt 4 consecutive FAS.
  - Required: o_lof = 1 the cycle after the 4th miss, valid drops, o_fas_err_cnt = 4; reacquires after 3 good FAS.
- **Gapped input:** random 50% valid duty during acquisition and in SYNC.
  - Required: same byte sequence and fas positions as the gap-free run; no output on idle cycles.
- **Async reset mid-frame in SYNC:** assert i_rst_n low for 1 cycle mid-frame.
  - Required: outputs at reset values immediately, o_lof = 1, clean reacquisition afterwards.

Source files
------------

// File: rtl/frame_align_pkg.sv
// Shared frame constants and aligner state type for the receive-side frame aligner.
package frame_align_pkg;

  localparam int unsigned FRAME_ROWS  = 4;
  localparam int unsigned FRAME_COLS  = 2176;
  localparam int unsigned FRAME_BYTES = FRAME_ROWS * FRAME_COLS;

  localparam logic [7:0] FAS_B0 = 8'hF6;
  localparam logic [7:0] FAS_B1 = 8'h28;

  localparam int unsigned ENTER_CNT = 2;
  localparam int unsigned EXIT_CNT  = 4;

  typedef enum logic [1:0] {
    StHunt    = 2'd0,
    StPresync = 2'd1,
    StSync    = 2'd2
  } sync_state_e;

endpackage

// File: rtl/fas_sync_fsm.sv
// Alignment state machine: hunt / presync / sync, with match and miss counting
// and a saturating FAS error counter. Advances only on accepted input beats.
module fas_sync_fsm
  import frame_align_pkg::*;
#(
  parameter int unsigned EnterCnt = ENTER_CNT,
  parameter int unsigned ExitCnt  = EXIT_CNT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        beat_i,
  input  logic        match_i,
  input  logic        check_i,
  output sync_state_e state_o,
  output sync_state_e state_next_o,
  output logic [15:0] fas_err_cnt_o
);

  sync_state_e state_q, state_d;
  logic [2:0]  match_cnt_q, match_cnt_d;
  logic [2:0]  miss_cnt_q, miss_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Next-state and counter update, evaluated once per valid beat.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (beat_i) begin
      unique case (state_q)
        StHunt: begin
          // Every beat is a candidate; check_i is meaningless until aligned.
          if (match_i) begin
            state_d     = StPresync;
            match_cnt_d = 3'd0;
          end
        end
        StPresync: begin
          if (check_i) begin
            if (match_i) begin
              match_cnt_d = match_cnt_q + 3'd1;
              if (match_cnt_d == 3'(EnterCnt)) begin
                state_d    = StSync;
                miss_cnt_d = 3'd0;
              end
            end else begin
              state_d = StHunt;
            end
          end
        end
        StSync: begin
          if (check_i) begin
            if (match_i) begin
              miss_cnt_d = 3'd0;
            end else begin
              miss_cnt_d = miss_cnt_q + 3'd1;
              if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
              if (miss_cnt_d == 3'(ExitCnt)) state_d = StHunt;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StHunt;
      match_cnt_q <= 3'd0;
      miss_cnt_q  <= 3'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign state_o       = state_q;
  assign state_next_o  = state_d;
  assign fas_err_cnt_o = err_cnt_q;

endmodule

// File: rtl/frame_align.sv
// Receive-side frame aligner: finds the two-byte FAS in the raw byte stream and
// forwards aligned bytes with a strobe on frame position 0 once in sync.
module frame_align #(
  parameter int unsigned FRAME_BYTES = frame_align_pkg::FRAME_BYTES,
  parameter logic [7:0]  FAS_B0      = frame_align_pkg::FAS_B0,
  parameter logic [7:0]  FAS_B1      = frame_align_pkg::FAS_B1,
  parameter int unsigned ENTER_CNT   = frame_align_pkg::ENTER_CNT,
  parameter int unsigned EXIT_CNT    = frame_align_pkg::EXIT_CNT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_data_valid,
  output logic [7:0]  o_frame_data,
  output logic        o_frame_data_valid,
  output logic        o_frame_data_fas,
  output logic        o_lof,
  output logic [15:0] o_fas_err_cnt
);
  import frame_align_pkg::*;

  localparam int unsigned PosW = $clog2(FRAME_BYTES);

  logic [7:0]      hold_q, hold_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            fas_q, fas_d;
  logic            lof_q, lof_d;
  logic            fas_hit;
  logic            at_check;
  sync_state_e     state_q, state_d;

  // pos_q is the frame position of the byte currently on i_rx_data.
  assign fas_hit  = (hold_q == FAS_B0) && (i_rx_data == FAS_B1);
  assign at_check = (pos_q == PosW'(1));

  fas_sync_fsm #(
    .EnterCnt(ENTER_CNT),
    .ExitCnt (EXIT_CNT)
  ) u_fas_sync_fsm (
    .clk_i        (i_clk),
    .rst_ni       (i_rst_n),
    .beat_i       (i_rx_data_valid),
    .match_i      (fas_hit),
    .check_i      (at_check),
    .state_o      (state_q),
    .state_next_o (state_d),
    .fas_err_cnt_o(o_fas_err_cnt)
  );

  // Hold register and frame position counter; a hunt match re-anchors position.
  always_comb begin
    hold_d = hold_q;
    pos_d  = pos_q;
    if (i_rx_data_valid) begin
      hold_d = i_rx_data;
      if ((state_q == StHunt) && fas_hit) begin
        pos_d = PosW'(2);
      end else if (pos_q == PosW'(FRAME_BYTES - 1)) begin
        pos_d = '0;
      end else begin
        pos_d = pos_q + PosW'(1);
      end
    end
  end

  // Output stage: emit the held byte when the post-beat state is SYNC.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    fas_d   = 1'b0;
    lof_d   = (state_d != StSync);
    if (i_rx_data_valid && (state_d == StSync)) begin
      data_d  = hold_q;
      valid_d = 1'b1;
      fas_d   = at_check;  // held byte sits one position behind pos_q
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q  <= 8'd0;
      pos_q   <= '0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      fas_q   <= 1'b0;
      lof_q   <= 1'b1;
    end else begin
      hold_q  <= hold_d;
      pos_q   <= pos_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fas_q   <= fas_d;
      lof_q   <= lof_d;
    end
  end

  assign o_frame_data       = data_q;
  assign o_frame_data_valid = valid_q;
  assign o_frame_data_fas   = fas_q;
  assign o_lof              = lof_q;

endmodule
